// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master Wishbone classic arbiter with a per-transfer
// bus watchdog.
//
// m0 (CPU) and m1 (SPI-slave master) share one bus towards the address
// decoder. Round-robin arbitration stops either master from starving the
// other. A slave that never acks is cut off by the watchdog, which aborts
// the bus cycle and returns a synthetic ack carrying TO_DATA.
//
// Ports:
//   wb_clk, wb_rst_n         clock, asynchronous active-low reset
//   wb_m0_* / wb_m1_*        master-side cyc/stb/we/sel/adr/dat in, ack/rdt out
//   wb_bus_*                 shared bus cyc/stb/we/sel/adr/dat out, ack/rdt in
//   to_clr                   synchronous clear of the timeout statistics
//   to_flag                  sticky "a timeout has occurred"
//   to_count                 number of timeouts, saturating at 255
//   grant                    one-hot current owner (bit0 = m0, bit1 = m1)
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT = 127,
  parameter logic [31:0] TO_DATA = 32'hdeaddead
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,

  input  logic        wb_m0_cyc,
  input  logic        wb_m0_stb,
  input  logic        wb_m0_we,
  input  logic [3:0]  wb_m0_sel,
  input  logic [31:0] wb_m0_adr,
  input  logic [31:0] wb_m0_dat,
  output logic        wb_m0_ack,
  output logic [31:0] wb_m0_rdt,

  input  logic        wb_m1_cyc,
  input  logic        wb_m1_stb,
  input  logic        wb_m1_we,
  input  logic [3:0]  wb_m1_sel,
  input  logic [31:0] wb_m1_adr,
  input  logic [31:0] wb_m1_dat,
  output logic        wb_m1_ack,
  output logic [31:0] wb_m1_rdt,

  output logic        wb_bus_cyc,
  output logic        wb_bus_stb,
  output logic        wb_bus_we,
  output logic [3:0]  wb_bus_sel,
  output logic [31:0] wb_bus_adr,
  output logic [31:0] wb_bus_dat,
  input  logic        wb_bus_ack,
  input  logic [31:0] wb_bus_rdt,

  input  logic        to_clr,
  output logic        to_flag,
  output logic [7:0]  to_count,
  output logic [1:0]  grant
);

  localparam int unsigned WDT_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  // Last wait cycle before the watchdog fires.
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // State is the one-hot grant in bits [1:0] plus a timeout bit in bit 2,
  // so the grant output is just the low two state bits.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    GNT0 = 3'b001,
    GNT1 = 3'b010,
    TMO0 = 3'b101,
    TMO1 = 3'b110
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last;      // 0: m0 owned the bus last, 1: m1
  logic               w_last_nxt;
  logic [WDT_W-1:0]   r_wdt;
  logic [WDT_W-1:0]   w_wdt_nxt;
  logic               w_timeout;   // watchdog fires on this edge
  logic               r_to_flag;
  logic [CNT_W-1:0]   r_to_count;

  // Signals of whichever master the state currently points at.
  logic               w_sel_m1;
  logic               w_cyc;
  logic               w_stb;
  logic               w_gnt_active;
  logic               w_gnt_any;

  assign w_sel_m1     = r_state[1];
  assign w_cyc        = w_sel_m1 ? wb_m1_cyc : wb_m0_cyc;
  assign w_stb        = w_sel_m1 ? wb_m1_stb : wb_m0_stb;
  assign w_gnt_active = (r_state == GNT0) || (r_state == GNT1);
  assign w_gnt_any    = r_state[0] | r_state[1];

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_wdt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_wdt   <= w_wdt_nxt;
    end
  end

  // Next-state, round-robin and watchdog logic.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_wdt_nxt   = r_wdt;
    w_timeout   = 1'b0;

    case (r_state)
      IDLE: begin
        w_wdt_nxt = '0;
        // On a tie the master that did not own the bus last wins.
        if (wb_m0_cyc && wb_m1_cyc) begin
          w_state_nxt = r_last ? GNT0 : GNT1;
        end else if (wb_m0_cyc) begin
          w_state_nxt = GNT0;
        end else if (wb_m1_cyc) begin
          w_state_nxt = GNT1;
        end
      end

      GNT0, GNT1: begin
        if (!w_cyc) begin
          // Owner released (or abandoned) its cycle.
          w_state_nxt = IDLE;
          w_last_nxt  = w_sel_m1;
          w_wdt_nxt   = '0;
        end else if (wb_bus_ack) begin
          // A slave ack always beats an expiring watchdog.
          w_wdt_nxt = '0;
        end else if (w_stb) begin
          if (r_wdt >= WDT_LAST) begin
            w_state_nxt = w_sel_m1 ? TMO1 : TMO0;
            w_wdt_nxt   = '0;
            w_timeout   = 1'b1;
          end else begin
            w_wdt_nxt = r_wdt + WDT_W'(1);
          end
        end
      end

      // One aborted cycle, then hand the bus straight back to the owner.
      TMO0: begin
        w_state_nxt = GNT0;
        w_wdt_nxt   = '0;
      end

      TMO1: begin
        w_state_nxt = GNT1;
        w_wdt_nxt   = '0;
      end

      default: begin
        w_state_nxt = IDLE;
        w_wdt_nxt   = '0;
      end
    endcase
  end

  // Timeout statistics; a concurrent clear wins over a new timeout.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_to_flag  <= 1'b0;
      r_to_count <= '0;
    end else if (to_clr) begin
      r_to_flag  <= 1'b0;
      r_to_count <= '0;
    end else if (w_timeout) begin
      r_to_flag <= 1'b1;
      if (r_to_count != CNT_MAX) begin
        r_to_count <= r_to_count + CNT_W'(1);
      end
    end
  end

  assign to_flag  = r_to_flag;
  assign to_count = r_to_count;
  assign grant    = r_state[1:0];

  // Shared bus: controls only while granted; cyc/stb forced low in TMOx
  // so the slave sees the cycle aborted.
  assign wb_bus_cyc = w_gnt_active & w_cyc;
  assign wb_bus_stb = w_gnt_active & w_stb;
  assign wb_bus_we  = w_gnt_any & (w_sel_m1 ? wb_m1_we : wb_m0_we);
  assign wb_bus_sel = w_gnt_any ? (w_sel_m1 ? wb_m1_sel : wb_m0_sel) : SEL_W'(0);
  assign wb_bus_adr = w_gnt_any ? (w_sel_m1 ? wb_m1_adr : wb_m0_adr) : DAT_W'(0);
  assign wb_bus_dat = w_gnt_any ? (w_sel_m1 ? wb_m1_dat : wb_m0_dat) : DAT_W'(0);

  // Master returns: slave ack only while granted, synthetic ack in TMOx.
  assign wb_m0_ack = ((r_state == GNT0) & wb_bus_ack) | (r_state == TMO0);
  assign wb_m1_ack = ((r_state == GNT1) & wb_bus_ack) | (r_state == TMO1);
  assign wb_m0_rdt = (r_state == TMO0) ? TO_DATA : wb_bus_rdt;
  assign wb_m1_rdt = (r_state == TMO1) ? TO_DATA : wb_bus_rdt;

endmodule
